uart_txrx: RTL and testbench
============================

// Module: uart_txrx
// PURPOSE
//  8N1 UART core: independent transmitter and receiver sharing one clock and reset.
//  TX serialises a parallel byte onto a line; RX recovers bytes from a line.
//  Used standalone or looped back (o_tx_SERIAL -> i_RX_SERIAL) for self-test.
//  Target clock 25 MHz.
// PARAMETERS
//  CLKS_PER_BIT  217  clock cycles per bit (25 MHz / 115200 baud); must be >= 4
// PORTS
//  i_CLK            in   1  system clock; all logic on rising edge
//  i_RESET          in   1  reset, synchronous, active-high
//  i_tx_DATA_READY  in   1  request to send i_tx_DATA (level, sampled while TX idle)
//  i_tx_DATA        in   8  byte to transmit
//  o_tx_SERIAL      out  1  TX serial line, idle high
//  o_tx_BUSY        out  1  high while a frame is in progress
//  o_tx_DONE        out  1  one-cycle pulse when a frame completes
//  i_RX_SERIAL      in   1  RX serial line (asynchronous)
//  o_RX_DATA        out  8  last received byte, held until next good frame
//  o_DATA_READY     out  1  one-cycle pulse when o_RX_DATA is updated
// BEHAVIOUR
//  Reset (synchronous, highest priority, aborts any frame): o_tx_SERIAL=1,
//   o_tx_BUSY=0, o_tx_DONE=0, o_RX_DATA=8'h00, o_DATA_READY=0; both FSMs -> IDLE.
//  Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit CLKS_PER_BIT cycles.
//  TX FSM: IDLE -> START -> DATA -> STOP -> DONE -> IDLE.
//   IDLE: line=1, BUSY=0. If i_tx_DATA_READY=1 at a clock edge, latch i_tx_DATA,
//    go START; line drops to 0 and BUSY=1 from the next cycle.
//   START/DATA/STOP: hold each bit exactly CLKS_PER_BIT cycles; 3-bit index for DATA.
//   DONE: one cycle, o_tx_DONE=1, BUSY=0, line=1; then IDLE.
//   i_tx_DATA_READY and i_tx_DATA ignored outside IDLE (latched copy is transmitted).
//   Request still high on return to IDLE -> next frame starts back-to-back.
//   Frame length start-edge to DONE pulse: 10*CLKS_PER_BIT cycles.
//  RX: i_RX_SERIAL passed through 2-flop synchroniser (2 cycles latency), reset to 1.
//  RX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
//   IDLE: synchronised line 0 -> START, counter cleared.
//   START: at (CLKS_PER_BIT-1)/2 cycles re-sample; 0 -> DATA, 1 -> IDLE (glitch reject).
//   DATA: sample every CLKS_PER_BIT cycles (bit centre), shift into bit[idx], 8 bits.
//   STOP: after CLKS_PER_BIT cycles sample: 1 -> load o_RX_DATA, pulse o_DATA_READY
//    one cycle; 0 (framing error) -> no update, no pulse.
//   CLEANUP: wait until line is 1, then IDLE (prevents a stuck-low line retriggering).
//  Ordering: RX decides at stop-bit centre, so in loopback o_DATA_READY rises about
//   CLKS_PER_BIT/2 cycles BEFORE o_tx_DONE; this ordering is required.
//  o_RX_DATA stable between pulses; RX only changes it on a good stop bit.
//  TX and RX fully independent; full-duplex operation allowed.
// TESTING
//  Loopback, CLKS_PER_BIT=217, 25 MHz: send 8'h31 -> o_DATA_READY pulse with
//   o_RX_DATA=8'h31, then o_tx_DONE; repeat 8'hFF, 8'h4A, 8'h01, 8'h2D, each issued
//   after previous o_tx_DONE, all received correctly.
//  TX timing: send 8'h31 -> line low 217 cycles, bits 1,0,0,0,1,1,0,0 of 217 each,
//   high 217; BUSY high 2170 cycles; DONE exactly one cycle.
//  Request held 2 cycles or pulsed while BUSY -> exactly one frame, latched byte unchanged.
//  RX glitch: low pulse of 50 cycles on idle line -> no o_DATA_READY, returns IDLE.
//  RX framing error: 8'hA5 with stop bit 0 -> no pulse, o_RX_DATA keeps old value.
//  Reset asserted mid-frame -> next cycle o_tx_SERIAL=1, BUSY=0; a subsequent 8'h4A
//   transfer completes correctly.

Source files
------------

// File: rtl/uart_txrx.sv
// 8N1 UART core: an independent transmitter and receiver sharing one clock and
// one synchronous active-high reset. Each bit lasts CLKS_PER_BIT clock cycles.
// The two halves share no state, so full-duplex and loopback operation both work.

module uart_txrx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  // Transmitter
  input  logic       i_tx_DATA_READY,
  input  logic [7:0] i_tx_DATA,
  output logic       o_tx_SERIAL,
  output logic       o_tx_BUSY,
  output logic       o_tx_DONE,
  // Receiver
  input  logic       i_RX_SERIAL,
  output logic [7:0] o_RX_DATA,
  output logic       o_DATA_READY
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  // Last cycle of a bit period, and the mid-point used to qualify a start bit
  localparam logic [CntW-1:0] CntBitEnd = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf   = CntW'((CLKS_PER_BIT - 1) / 2);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------

  localparam logic [2:0] TxIdle  = 3'd0;
  localparam logic [2:0] TxStart = 3'd1;
  localparam logic [2:0] TxData  = 3'd2;
  localparam logic [2:0] TxStop  = 3'd3;
  localparam logic [2:0] TxDone  = 3'd4;

  logic [2:0]      tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CntBitEnd);

  // TX next state: request is only looked at in idle, the byte is latched there
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (i_tx_DATA_READY) begin
          tx_byte_d  = i_tx_DATA;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TxStop;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TxDone;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxDone: begin
        tx_state_d = TxIdle;
      end
      default: begin
        tx_state_d = TxIdle;
      end
    endcase
  end

  // TX state registers, synchronous reset aborts any frame
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // TX outputs decoded from the registered state, so they are glitch-free per cycle
  always_comb begin
    o_tx_SERIAL = 1'b1;
    o_tx_BUSY   = 1'b0;
    o_tx_DONE   = 1'b0;
    case (tx_state_q)
      TxStart: begin
        o_tx_SERIAL = 1'b0;
        o_tx_BUSY   = 1'b1;
      end
      TxData: begin
        o_tx_SERIAL = tx_byte_q[tx_idx_q];
        o_tx_BUSY   = 1'b1;
      end
      TxStop: begin
        o_tx_BUSY = 1'b1;
      end
      TxDone: begin
        o_tx_DONE = 1'b1;
      end
      default: begin
        o_tx_SERIAL = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------

  localparam logic [2:0] RxIdle    = 3'd0;
  localparam logic [2:0] RxStart   = 3'd1;
  localparam logic [2:0] RxData    = 3'd2;
  localparam logic [2:0] RxStop    = 3'd3;
  localparam logic [2:0] RxCleanup = 3'd4;

  logic            rx_meta_q, rx_sync_q;
  logic [2:0]      rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_bit_end;

  assign rx_bit_end = (rx_cnt_q == CntBitEnd);

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_SERIAL;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next state: qualify start at half a bit, then sample each following bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d = '0;
          // Line back high by mid start bit: treat as a glitch
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          // Only a valid stop bit publishes the byte
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
          rx_state_d = RxCleanup;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxCleanup: begin
        // A line stuck low after a framing error must not look like a new start bit
        if (rx_sync_q) begin
          rx_state_d = RxIdle;
        end
      end
      default: begin
        rx_state_d = RxIdle;
      end
    endcase
  end

  // RX state registers, synchronous reset clears the received byte and the strobe
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign o_RX_DATA    = rx_data_q;
  assign o_DATA_READY = rx_valid_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: loopback frames checked bit-by-bit against an ideal 8N1
// waveform, plus directly driven RX frames (good, framing error, glitch) and reset.

module tb_uart_txrx;

  localparam int Cpb = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_serial, tx_busy, tx_done;
  logic       rx_line, drv_rx, loop_en;
  logic [7:0] rx_data;
  logic       rx_ready;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rx;

  always #20 clk = ~clk;

  assign rx_line = loop_en ? tx_serial : drv_rx;

  uart_txrx #(.CLKS_PER_BIT(Cpb)) dut (
    .i_CLK           (clk),
    .i_RESET         (rst),
    .i_tx_DATA_READY (tx_req),
    .i_tx_DATA       (tx_data),
    .o_tx_SERIAL     (tx_serial),
    .o_tx_BUSY       (tx_busy),
    .o_tx_DONE       (tx_done),
    .i_RX_SERIAL     (rx_line),
    .o_RX_DATA       (rx_data),
    .o_DATA_READY    (rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal line level for bit slot n of an 8N1 frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  // Send one byte in loopback and check the line, BUSY, DONE and the received byte
  task automatic send_tx(input logic [7:0] b, input int hold, input bit mid_pulse);
    int match;
    int busy_cnt = 0;
    int done_cnt = 0;
    int rx_pulses = 0;
    int rx_at = -1;
    int extra = 0;
    int g;
    logic [7:0] rx_got = 8'h00;
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = b;
    @(posedge clk);
    #1 tx_data = 8'($urandom);
    for (int bi = 0; bi < 10; bi++) begin
      match = 0;
      for (int c = 0; c < Cpb; c++) begin
        g = bi * Cpb + c;
        @(negedge clk);
        if (tx_serial === frame_bit(b, bi)) match++;
        if (tx_busy) busy_cnt++;
        if (tx_done) done_cnt++;
        if (rx_ready) begin
          rx_pulses++;
          rx_at  = g;
          rx_got = rx_data;
        end
        if (g == hold - 1) tx_req = 1'b0;
        if (mid_pulse && bi == 4 && c == 5) begin
          tx_req  = 1'b1;
          tx_data = 8'($urandom);
        end
        if (mid_pulse && bi == 4 && c == 6) tx_req = 1'b0;
      end
      check($sformatf("tx_bit%0d_%02h", bi, b), match, Cpb);
    end
    check($sformatf("busy_len_%02h", b), busy_cnt, 10 * Cpb);
    check($sformatf("done_early_%02h", b), done_cnt, 0);
    check($sformatf("rx_pulses_%02h", b), rx_pulses, 1);
    check($sformatf("rx_byte_%02h", b), 32'(rx_got), 32'(b));
    check($sformatf("rx_before_done_%02h", b),
          32'(rx_at >= 9 * Cpb && rx_at < 10 * Cpb), 32'd1);
    @(negedge clk);
    check($sformatf("done_pulse_%02h", b), 32'(tx_done), 32'd1);
    check($sformatf("done_busy_%02h", b), 32'(tx_busy), 32'd0);
    check($sformatf("done_line_%02h", b), 32'(tx_serial), 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (tx_busy || tx_done || !tx_serial) extra++;
    end
    check($sformatf("single_frame_%02h", b), extra, 0);
    last_rx = b;
    check($sformatf("rx_hold_%02h", b), 32'(rx_data), 32'(last_rx));
  endtask

  // Drive one frame straight onto the RX line; stop_ok=0 makes a framing error
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    int pulses = 0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < Cpb; c++) begin
        @(negedge clk);
        if (rx_ready) pulses++;
        drv_rx = (bi == 9) ? stop_ok : frame_bit(b, bi);
      end
    end
    drv_rx = 1'b1;
    repeat (Cpb) begin
      @(negedge clk);
      if (rx_ready) pulses++;
    end
    if (stop_ok) last_rx = b;
    check($sformatf("rxd_pulses_%02h_s%0d", b, stop_ok), pulses, 32'(stop_ok));
    check($sformatf("rxd_byte_%02h_s%0d", b, stop_ok), 32'(rx_data), 32'(last_rx));
  endtask

  initial begin
    int pulses;
    logic [7:0] lb [5];
    lb[0] = 8'h31; lb[1] = 8'hFF; lb[2] = 8'h4A; lb[3] = 8'h01; lb[4] = 8'h2D;
    rst     = 1'b1;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    drv_rx  = 1'b1;
    loop_en = 1'b1;
    last_rx = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", 32'(tx_serial), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_rxready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Loopback sequence, each issued after the previous DONE
    for (int i = 0; i < 5; i++) send_tx(lb[i], 1, 1'b0);

    // Request held two cycles, then a request pulsed mid-frame
    send_tx(8'h5C, 2, 1'b0);
    send_tx(8'h93, 1, 1'b1);

    // Random bytes, request lengths and mid-frame pulses
    for (int i = 0; i < 5; i++)
      send_tx(8'($urandom), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a frame
    @(posedge clk);
    #1 tx_req = 1'b1;
    tx_data = 8'h77;
    @(posedge clk);
    #1 tx_req = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_line", 32'(tx_serial), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    check("midrst_rxdata", 32'(rx_data), 32'd0);
    check("midrst_rxready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    last_rx = 8'h00;
    repeat (5) @(negedge clk);
    send_tx(8'h4A, 1, 1'b0);

    // Receiver driven directly
    @(negedge clk);
    loop_en = 1'b0;
    drv_rx  = 1'b1;
    repeat (4) @(negedge clk);

    // 50-cycle low glitch on an idle line must be rejected
    pulses = 0;
    drv_rx = 1'b0;
    repeat (50) @(negedge clk);
    drv_rx = 1'b1;
    repeat (3 * Cpb) begin
      @(negedge clk);
      if (rx_ready) pulses++;
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_rxdata", 32'(rx_data), 32'(last_rx));

    rx_frame(8'hA5, 1'b0);
    rx_frame(8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
